// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - states, opcodes and select encodings for the multicycle controller
// Optional TRAP state is present only when ILLEGAL_TRAP_EN is defined.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_JAL,
        S_BEQ
`ifdef ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    function automatic logic [1:0] imm_for_op(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps aluop and instruction function fields to the ALU operation
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // only R-type (op[5]=1) can encode sub; addi ignores instr[30]
                    3'b000:  alucontrol = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RISC-V control FSM with retired-instruction counter
// Define ILLEGAL_TRAP_EN to park illegal opcodes in a TRAP state instead of treating them as NOPs.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        zero,
    output logic        pcwrite,
    output logic        adrsrc,
    output logic        memwrite,
    output logic        irwrite,
    output logic        regwrite,
    output logic [1:0]  resultsrc,
    output logic [1:0]  alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  immsrc,
    output logic [2:0]  alucontrol,
    output logic [31:0] instret,
    output logic        illegal
);

    state_t     state, next_state;
    logic       pcupdate, branch, retire;
    logic       ir_en, reg_en, mem_en;
    logic [1:0] aluop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_FETCH;
            instret <= '0;
        end else begin
            state <= next_state;
            if (retire)
                instret <= instret + 32'd1;
        end
    end

    always_comb begin
        next_state = S_FETCH;
        retire     = 1'b0;
        pcupdate   = 1'b0;
        branch     = 1'b0;
        ir_en      = 1'b0;
        reg_en     = 1'b0;
        mem_en     = 1'b0;
        adrsrc     = 1'b0;
        resultsrc  = RES_ALUOUT;
        alusrca    = SRCA_PC;
        alusrcb    = SRCB_RS2;
        aluop      = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                next_state = S_DECODE;
                ir_en      = 1'b1;
                pcupdate   = 1'b1;
                alusrcb    = SRCB_FOUR;
                resultsrc  = RES_ALURESULT;
            end
            S_DECODE: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXECUTER;
                    OP_I:         next_state = S_EXECUTEI;
                    OP_JAL:       next_state = S_JAL;
                    OP_BEQ:       next_state = S_BEQ;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        next_state = S_TRAP;
`else
                        next_state = S_FETCH;
                        retire     = 1'b1;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                alusrca    = SRCA_RS1;
                alusrcb    = SRCB_IMM;
            end
            S_MEMREAD: begin
                next_state = S_MEMWB;
                adrsrc     = 1'b1;
            end
            S_MEMWB: begin
                retire    = 1'b1;
                resultsrc = RES_DATA;
                reg_en    = 1'b1;
            end
            S_MEMWRITE: begin
                retire = 1'b1;
                adrsrc = 1'b1;
                mem_en = 1'b1;
            end
            S_EXECUTER: begin
                next_state = S_ALUWB;
                alusrca    = SRCA_RS1;
                aluop      = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                next_state = S_ALUWB;
                alusrca    = SRCA_RS1;
                alusrcb    = SRCB_IMM;
                aluop      = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                retire = 1'b1;
                reg_en = 1'b1;
            end
            S_JAL: begin
                next_state = S_ALUWB;
                alusrca    = SRCA_OLDPC;
                alusrcb    = SRCB_FOUR;
                pcupdate   = 1'b1;
            end
            S_BEQ: begin
                retire  = 1'b1;
                alusrca = SRCA_RS1;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: next_state = S_TRAP;
`endif
            default: next_state = S_FETCH;
        endcase
    end

    // write enables are held low for the whole reset pulse, not just until the next edge
    assign pcwrite  = ~reset & (pcupdate | (branch & zero));
    assign irwrite  = ~reset & ir_en;
    assign regwrite = ~reset & reg_en;
    assign memwrite = ~reset & mem_en;
    assign immsrc   = imm_for_op(op);

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op5        (op[5]),
        .alucontrol (alucontrol)
    );

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            illegal <= 1'b0;
        else if (next_state == S_TRAP)
            illegal <= 1'b1;
    end
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multicycle RISC-V core. One datapath (shared instruction/data memory, one ALU, IR/ALUOut/Data registers) is sequenced through fetch, decode, execute, memory and writeback steps. The block drives every mux select and write enable of that datapath from the current instruction's opcode/funct fields and the ALU `zero` flag. It also keeps a retired-instruction counter.

## Interface
- No parameters.
- `clk` input 1: core clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `op` input 7: `instr[6:0]` from IR.
- `funct3` input 3: `instr[14:12]`.
- `funct7b5` input 1: `instr[30]`.
- `zero` input 1: ALU zero flag.
- `pcwrite` output 1: PC register enable.
- `adrsrc` output 1: memory address select (0 = PC, 1 = result).
- `memwrite` output 1: memory write enable.
- `irwrite` output 1: IR/OldPC enable.
- `regwrite` output 1: register file write enable.
- `resultsrc` output 2: 00 ALUOut, 01 Data, 10 ALUResult.
- `alusrca` output 2: 00 PC, 01 OldPC, 10 rs1.
- `alusrcb` output 2: 00 rs2, 01 immext, 10 constant 4.
- `immsrc` output 2: 00 I, 01 S, 10 B, 11 J.
- `alucontrol` output 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `instret` output 32: retired-instruction count.
- `illegal` output 1: sticky illegal-opcode flag.

## Operation
- Opcodes:
  - lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, jal 1101111, beq 1100011.
  - Any other opcode is illegal.
- State transitions:
  - FETCH→DECODE.
  - DECODE: lw/sw→MEMADR, R→EXECUTER, I→EXECUTEI, jal→JAL, beq→BEQ, illegal→FETCH (see Configuration).
  - MEMADR: lw→MEMREAD, sw→MEMWRITE.
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECUTER/EXECUTEI/JAL→ALUWB→FETCH.
  - BEQ→FETCH.
- State outputs (Moore). Each output not listed for a state is 0.
  - FETCH: irwrite, pcupdate, alusrcb=10, resultsrc=10.
  - DECODE: alusrca=01, alusrcb=01.
  - MEMADR: alusrca=10, alusrcb=01.
  - MEMREAD: adrsrc.
  - MEMWB: resultsrc=01, regwrite.
  - MEMWRITE: adrsrc, memwrite.
  - EXECUTER: alusrca=10, aluop=10.
  - EXECUTEI: alusrca=10, alusrcb=01, aluop=10.
  - ALUWB: regwrite.
  - JAL: alusrca=01, alusrcb=10, pcupdate.
  - BEQ: alusrca=10, aluop=01, branch.
- `pcwrite = pcupdate | (branch & zero)`.
- `immsrc` is combinational from `op`: lw/I 00, sw 01, beq 10, jal 11, others 00.
- ALU decode (`alucontrol`):
  - aluop 00 → add; aluop 01 → sub.
  - aluop 10, funct3 000: sub if `funct7b5 & op[5]`, else add.
  - aluop 10, funct3 010 → slt; 110 → or; 111 → and.
  - aluop 10, any other funct3 → add.
- `instret` increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ. It wraps 0xFFFFFFFF→0.

## Timing
- Reset values: state FETCH, `instret`=0, `illegal`=0.
- While `reset` is high, `pcwrite`, `irwrite`, `regwrite` and `memwrite` are forced 0. The other outputs follow the FETCH decode.
- Reset asserted mid-instruction returns to FETCH immediately. No partial write occurs after assertion.
- Cycles per instruction, FETCH to next FETCH:
  - beq 3.
  - R, I, sw, jal 4.
  - lw 5.
- `op`/`funct*` are sampled only in DECODE, MEMADR and EXECUTE*. IR is stable there because `irwrite` is high only in FETCH.
- `zero` is consumed only in BEQ, in the same cycle.

## Configuration
- `ILLEGAL_TRAP_EN` defined:
  - An illegal opcode in DECODE enters state TRAP and sets `illegal`=1.
  - TRAP holds all enables 0 until reset.
  - No `instret` increment.
- `ILLEGAL_TRAP_EN` undefined:
  - An illegal opcode in DECODE returns to FETCH (treated as a NOP) and increments `instret`.
  - `illegal` is tied 0.
  - The TRAP state is not compiled.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - state enum;
  - opcode localparams;
  - `aluop`, `resultsrc`, `alusrca`/`alusrcb` and `immsrc` encodings;
  - `alucontrol` encodings.
- Sub-module `alu_decoder`: combinational, `aluop`/`funct3`/`funct7b5`/`op[5]` → `alucontrol`.
- The FSM, output decode and `instret` live in the top module.

## Test plan
- Reset asserted mid-MEMWB, then released → state FETCH, `regwrite`=0 during reset, `instret`=0, `irwrite`=1 on the first cycle after release.
- lw (op 0000011) → FETCH, DECODE, MEMADR, MEMREAD, MEMWB; `adrsrc`=1 in MEMREAD; `regwrite`=1 with `resultsrc`=01 in cycle 5; `instret` +1.
- R-type sub (funct3 000, funct7b5 1) → `alucontrol`=001 in EXECUTER, 4 cycles total. Same with funct7b5 0 → 000.
- beq with `zero`=1 → `pcwrite`=1 in BEQ, `alucontrol`=001. With `zero`=0 → `pcwrite`=0. Both take 3 cycles.
- sw then jal → `memwrite`=1 only in cycle 4 of sw; jal has `pcwrite`=1 in JAL and `regwrite`=1 in ALUWB; `immsrc` is 01 then 11.
- Opcode 1111111:
  - with `ILLEGAL_TRAP_EN`, `illegal`=1 and all enables stay 0 for 10+ cycles;
  - without it, the FSM returns to FETCH and `instret` +1.
